rssi_tracker: RTL and testbench

RSSI_TRACKER -- requirements
Module: rssi_tracker

---
 rtl/rssi_pkg.sv | 16 +
 rtl/sync_edge.sv | 33 +++
 rtl/rssi_tracker.sv | 186 ++++++++++++++++++
 tb/tb_rssi_tracker.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rssi_pkg.sv
// Shared definitions for the RSSI tracker.
//   POW_WIDTH_DEF / AVG_LOG2_DEF : default power-sum width and averaging window log2
//   CNT_WIDTH                    : width of the saturating accepted-sample counter
//   state_t                      : tracker FSM encoding (FILL while the window fills, TRACK once full)
package rssi_pkg;

  localparam int POW_WIDTH_DEF = 26;
  localparam int AVG_LOG2_DEF  = 3;
  localparam int CNT_WIDTH     = 16;

  typedef enum logic {
    FILL  = 1'b0,
    TRACK = 1'b1
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector. Brings a slow
// strobe from a foreign clock domain (clk_100hz, clk_1k, ...) into clk and
// turns each rising edge into a single-cycle pulse.
//   clk   : destination clock
//   rstn  : asynchronous active-low reset; all flops clear to 0
//   din   : asynchronous input level
//   pulse : one-cycle pulse per rising edge of the synchronised level
module sync_edge (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic pulse
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign pulse = sync & ~prev;

endmodule

// File: rtl/rssi_tracker.sv
// RSSI tracker: moving average of per-window power sums, peak hold,
// hysteretic carrier detect with a rising-edge interrupt, and a saturating
// count of accepted samples.
//
// Handshake: a sample is accepted on the clk edge where the synchronised
// pow_sync rising-edge strobe and en are both 1; there is no back-pressure,
// pow_sum must simply be stable while the strobe crosses the synchroniser.
//
//   clk, rstn   : system clock, asynchronous active-low reset
//   en          : tracker enable; dropping it flushes the averaging window
//   pow_sync    : asynchronous window strobe, pow_sum is sampled on its rise
//   pow_sum     : window power sum
//   thr_hi      : detect-assert threshold (rssi_avg >= thr_hi sets)
//   thr_lo      : detect-release threshold (rssi_avg < thr_lo clears)
//   peak_clr    : single-cycle peak-hold clear
//   rssi_avg    : moving average, zero-extended to 32 bits
//   avg_valid   : averaging window is full
//   rssi_peak   : maximum accepted pow_sum since the last clear
//   sig_detect  : hysteretic carrier-detect level
//   detect_irq  : one-cycle pulse on sig_detect 0->1
//   sample_cnt  : saturating count of accepted samples
//   fsm_state   : current tracker state (FILL/TRACK), for observation
module rssi_tracker
  import rssi_pkg::*;
#(
  parameter int POW_WIDTH = POW_WIDTH_DEF,
  parameter int AVG_LOG2  = AVG_LOG2_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic                 pow_sync,
  input  logic [POW_WIDTH-1:0] pow_sum,
  input  logic [POW_WIDTH-1:0] thr_hi,
  input  logic [POW_WIDTH-1:0] thr_lo,
  input  logic                 peak_clr,
  output logic [31:0]          rssi_avg,
  output logic                 avg_valid,
  output logic [POW_WIDTH-1:0] rssi_peak,
  output logic                 sig_detect,
  output logic                 detect_irq,
  output logic [CNT_WIDTH-1:0] sample_cnt,
  output state_t               fsm_state
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = POW_WIDTH + AVG_LOG2;

  logic                 smp;
  logic                 acc;
  logic [POW_WIDTH-1:0] buf_q [DEPTH];
  logic [AVG_LOG2-1:0]  wr_ptr;
  logic [SUM_W-1:0]     sum;
  logic [SUM_W-1:0]     sum_nxt;
  logic [POW_WIDTH-1:0] avg_q;
  state_t               state;
  state_t               state_nxt;
  logic                 track;

  sync_edge u_sync_edge (
    .clk   (clk),
    .rstn  (rstn),
    .din   (pow_sync),
    .pulse (smp)
  );

  assign acc = smp & en;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= FILL;
    else       state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  // wr_ptr restarts at 0 whenever en drops, so the write into the last slot
  // is exactly the 2^AVG_LOG2-th accepted sample of the current fill.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (!en)                         state_nxt = FILL;
        else if (acc && (wr_ptr == '1))  state_nxt = TRACK;
      end
      TRACK: begin
        if (!en) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    track     = (state == TRACK);
    fsm_state = state;
  end

  // ---------------- Moving-average window ----------------
  // Subtract the outgoing slot before adding the new sample: sum always
  // contains the outgoing value, so the intermediate never exceeds the
  // 2^AVG_LOG2 * max bound and SUM_W bits suffice.
  assign sum_nxt = sum - SUM_W'(buf_q[wr_ptr]) + SUM_W'(pow_sum);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (!en) begin
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else if (acc) begin
      buf_q[wr_ptr] <= pow_sum;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum    <= '0;
      wr_ptr <= '0;
    end else if (!en) begin
      sum    <= '0;
      wr_ptr <= '0;
    end else if (acc) begin
      sum    <= sum_nxt;
      wr_ptr <= wr_ptr + AVG_LOG2'(1);
    end
  end

  // avg_valid is registered alongside avg_q so it rises together with the
  // first full-window average, one cycle after the FSM enters TRACK.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      avg_q     <= '0;
      avg_valid <= 1'b0;
    end else if (!en) begin
      avg_q     <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_q     <= POW_WIDTH'(sum >> AVG_LOG2);
      avg_valid <= track;
    end
  end

  assign rssi_avg = 32'(avg_q);

  // ---------------- Carrier detect ----------------
  // Evaluated only once the average is meaningful; thresholds are applied
  // literally even if thr_lo > thr_hi.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sig_detect <= 1'b0;
      detect_irq <= 1'b0;
    end else if (!en || !track || !avg_valid) begin
      sig_detect <= 1'b0;
      detect_irq <= 1'b0;
    end else begin
      detect_irq <= 1'b0;
      if (!sig_detect && (avg_q >= thr_hi)) begin
        sig_detect <= 1'b1;
        detect_irq <= 1'b1;
      end else if (sig_detect && (avg_q < thr_lo)) begin
        sig_detect <= 1'b0;
      end
    end
  end

  // ---------------- Peak hold ----------------
  // A clear coinciding with a sample restarts the hold at that sample.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rssi_peak <= '0;
    end else if (acc && (peak_clr || (pow_sum > rssi_peak))) begin
      rssi_peak <= pow_sum;
    end else if (en && peak_clr) begin
      rssi_peak <= '0;
    end
  end

  // ---------------- Sample counter ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sample_cnt <= '0;
    end else if (acc && (sample_cnt != '1)) begin
      sample_cnt <= sample_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_rssi_tracker.sv
// Testbench for rssi_tracker: directed scenarios followed by randomized
// strobes, every output compared to a window/queue reference model.
module tb_rssi_tracker;
  import rssi_pkg::*;

  localparam int PW  = 26;
  localparam int WIN = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          en;
  logic          pow_sync;
  logic [PW-1:0] pow_sum;
  logic [PW-1:0] thr_hi;
  logic [PW-1:0] thr_lo;
  logic          peak_clr;
  logic [31:0]   rssi_avg;
  logic          avg_valid;
  logic [PW-1:0] rssi_peak;
  logic          sig_detect;
  logic          detect_irq;
  logic [15:0]   sample_cnt;
  state_t        fsm_state;

  int n_checks = 0;
  int n_err    = 0;
  int irq_seen = 0;

  // reference model state
  longint      win[$];
  int          n_since_en;
  int          m_cnt;
  longint      m_peak;
  bit          m_det;
  int          m_irqs;
  bit          m_en;

  rssi_tracker #(.POW_WIDTH(PW), .AVG_LOG2(3)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .pow_sync   (pow_sync),
    .pow_sum    (pow_sum),
    .thr_hi     (thr_hi),
    .thr_lo     (thr_lo),
    .peak_clr   (peak_clr),
    .rssi_avg   (rssi_avg),
    .avg_valid  (avg_valid),
    .rssi_peak  (rssi_peak),
    .sig_detect (sig_detect),
    .detect_irq (detect_irq),
    .sample_cnt (sample_cnt),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // counts high cycles of detect_irq, so a stretched pulse shows up as extra
  always @(negedge clk) if (detect_irq === 1'b1) irq_seen++;

  // ---------------- reference model ----------------
  function automatic longint win_avg();
    longint s = 0;
    foreach (win[i]) s += win[i];
    return s / WIN;
  endfunction

  function automatic void model_reset();
    win.delete();
    n_since_en = 0;
    m_cnt      = 0;
    m_peak     = 0;
    m_det      = 0;
  endfunction

  function automatic void model_drop_en();
    win.delete();
    n_since_en = 0;
    m_det      = 0;
  endfunction

  function automatic void model_accept(input longint v, input bit clr);
    win.push_back(v);
    if (win.size() > WIN) void'(win.pop_front());
    n_since_en++;
    if (m_cnt < 65535) m_cnt++;
    if (clr || v > m_peak) m_peak = v;
  endfunction

  function automatic void model_eval();
    longint a = win_avg();
    if (n_since_en < WIN) m_det = 0;
    else if (!m_det && a >= longint'(thr_hi)) begin
      m_det = 1;
      m_irqs++;
    end else if (m_det && a < longint'(thr_lo)) m_det = 0;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit full;
    full = (n_since_en >= WIN);
    chk({tag, "/avg"},   64'(rssi_avg),   64'(win_avg()));
    chk({tag, "/valid"}, 64'(avg_valid),  64'(full));
    chk({tag, "/state"}, 64'(fsm_state),  full ? 64'(TRACK) : 64'(FILL));
    chk({tag, "/peak"},  64'(rssi_peak),  64'(m_peak));
    chk({tag, "/det"},   64'(sig_detect), 64'(m_det));
    chk({tag, "/cnt"},   64'(sample_cnt), 64'(m_cnt));
    chk({tag, "/irqs"},  64'(irq_seen),   64'(m_irqs));
  endtask

  // ---------------- drivers ----------------
  // pow_sync is raised just after a falling edge; the synchronised strobe is
  // accepted on the third rising edge, which is when peak_clr is held high.
  task automatic strobe(input logic [PW-1:0] v, input bit clr);
    @(negedge clk);
    pow_sum  = v;
    pow_sync = 1'b1;
    @(negedge clk);
    @(negedge clk);
    peak_clr = clr;
    @(negedge clk);
    peak_clr = 1'b0;
    repeat (3) @(negedge clk);
    pow_sync = 1'b0;
    repeat (4) @(negedge clk);
    if (m_en) begin
      model_accept(longint'(v), clr);
      model_eval();
    end
  endtask

  task automatic strobes(input logic [PW-1:0] v, input int n);
    for (int i = 0; i < n; i++) strobe(v, 1'b0);
  endtask

  task automatic clear_peak();
    @(negedge clk);
    peak_clr = 1'b1;
    @(negedge clk);
    peak_clr = 1'b0;
    if (m_en) m_peak = 0;
  endtask

  task automatic set_thr(input logic [PW-1:0] hi, input logic [PW-1:0] lo);
    @(negedge clk);
    thr_hi = hi;
    thr_lo = lo;
    repeat (3) @(negedge clk);
    model_eval();
  endtask

  task automatic drop_en();
    @(negedge clk);
    en   = 1'b0;
    m_en = 0;
    model_drop_en();
    @(negedge clk);
  endtask

  task automatic raise_en();
    @(negedge clk);
    en   = 1'b1;
    m_en = 1;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int irq_base;
    logic [PW-1:0] v;

    rstn     = 1'b0;
    en       = 1'b0;
    pow_sync = 1'b0;
    pow_sum  = '0;
    thr_hi   = '1;
    thr_lo   = '0;
    peak_clr = 1'b0;
    m_en     = 0;
    m_irqs   = 0;
    model_reset();

    repeat (3) @(negedge clk);
    check_all("reset");
    chk("reset/irq", 64'(detect_irq), 64'd0);
    rstn = 1'b1;
    raise_en();

    // constant input fills the window
    strobes(26'd1000, 7);
    check_all("fill7");
    chk("fill7/valid_low", 64'(avg_valid), 64'd0);
    strobe(26'd1000, 1'b0);
    check_all("fill8");
    chk("fill8/avg1000", 64'(rssi_avg), 64'd1000);
    chk("fill8/valid_high", 64'(avg_valid), 64'd1);

    // peak hold
    clear_peak();
    chk("peak/clr", 64'(rssi_peak), 64'd0);
    strobe(26'd10, 1'b0);
    strobe(26'd50, 1'b0);
    strobe(26'd20, 1'b0);
    check_all("peak3");
    chk("peak/50", 64'(rssi_peak), 64'd50);
    strobe(26'd7, 1'b1);
    check_all("peak_clr_smp");
    chk("peak/7", 64'(rssi_peak), 64'd7);

    // hysteresis 200 -> 600 -> 400 -> 250
    drop_en();
    raise_en();
    set_thr(26'd500, 26'd300);
    irq_base = irq_seen;
    strobes(26'd200, 8);
    check_all("hyst200");
    chk("hyst200/det", 64'(sig_detect), 64'd0);
    strobes(26'd600, 8);
    check_all("hyst600");
    chk("hyst600/det", 64'(sig_detect), 64'd1);
    strobes(26'd400, 8);
    check_all("hyst400");
    chk("hyst400/det", 64'(sig_detect), 64'd1);
    strobes(26'd250, 8);
    check_all("hyst250");
    chk("hyst250/det", 64'(sig_detect), 64'd0);
    chk("hyst/one_irq", 64'(irq_seen - irq_base), 64'd1);

    // enable drop while detecting
    strobes(26'd600, 8);
    check_all("redetect");
    @(negedge clk);
    en   = 1'b0;
    m_en = 0;
    model_drop_en();
    @(negedge clk);
    check_all("en_drop");
    chk("en_drop/avg0", 64'(rssi_avg), 64'd0);
    chk("en_drop/det0", 64'(sig_detect), 64'd0);
    strobe(26'd12345, 1'b0);
    strobe(26'd999, 1'b0);
    check_all("en_low_strobes");

    // full scale and wrap
    raise_en();
    set_thr('1, 26'd0);
    strobes('1, 20);
    check_all("fullscale");
    chk("fullscale/avg", 64'(rssi_avg), 64'h3FF_FFFF);
    strobes(26'd0, 8);
    check_all("zeros");
    chk("zeros/avg", 64'(rssi_avg), 64'd0);

    // randomized strobes with random thresholds, clears and enable drops
    for (int i = 0; i < 60; i++) begin
      if (i % 15 == 0) begin
        logic [PW-1:0] lo;
        lo = PW'($urandom_range(0, 1 << 20));
        set_thr(lo + PW'($urandom_range(0, 1 << 19)), lo);
      end
      if ($urandom_range(0, 19) == 0) begin
        drop_en();
        raise_en();
      end
      if ($urandom_range(0, 9) == 0) v = PW'($urandom_range(0, (1 << PW) - 1));
      else                           v = PW'($urandom_range(0, 1 << 21));
      strobe(v, ($urandom_range(0, 7) == 0));
      check_all("rand");
    end

    // asynchronous reset mid-operation
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst/irq", 64'(detect_irq), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    strobe(26'd77, 1'b0);
    check_all("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
